// File: rtl/gate_interlock.sv
// -----------------------------------------------------------------------------
// gate_interlock
//
// Safety interlock between the half-bridge PWM generator and the gate-driver
// pins. It enforces a hardware minimum deadtime, turns simultaneous
// highside/lowside requests into a latched fault, and latches the external
// fault input. While a fault is latched both gates are held off until software
// clears the fault.
//
// Ports:
//   clock            system clock, all logic on the rising edge
//   reset            asynchronous, active-low; clears all state, outputs low
//   enable           1 = gates may be driven, 0 = both gates forced off
//   highside_request highside output of the upstream PWM
//   lowside_request  lowside output of the upstream PWM
//   min_deadtime     minimum deadtime in clocks, sampled on entry to DEAD
//   fault            external fault, level, active-high, already synchronised
//   fault_clear      single-cycle strobe; leaves FAULT only while fault is low
//   highside_gate    registered highside gate drive
//   lowside_gate     registered lowside gate drive
//   fault_latched    high while in FAULT
//   fault_cause      0 none, 1 external fault, 2 request overlap
//   state            FSM state (IDLE=0 DEAD=1 HS_ON=2 LS_ON=3 FAULT=4)
//
// Handshake: there is no valid/ready traffic in this block. Requests are plain
// levels sampled on every rising edge; fault_clear is a one-cycle strobe that
// is acted on only in the cycle it is high.
// -----------------------------------------------------------------------------
module gate_interlock #(
  parameter int bitwidth = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                highside_request,
  input  logic                lowside_request,
  input  logic [bitwidth-1:0] min_deadtime,
  input  logic                fault,
  input  logic                fault_clear,
  output logic                highside_gate,
  output logic                lowside_gate,
  output logic                fault_latched,
  output logic [1:0]          fault_cause,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEAD  = 3'd1,
    HS_ON = 3'd2,
    LS_ON = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [1:0]          CAUSE_NONE    = 2'd0;
  localparam logic [1:0]          CAUSE_EXT     = 2'd1;
  localparam logic [1:0]          CAUSE_OVERLAP = 2'd2;
  localparam logic [bitwidth-1:0] CNT_ONE       = {{(bitwidth-1){1'b0}}, 1'b1};

  state_t              cur_state;
  state_t              nxt_state;
  logic [bitwidth-1:0] cnt;
  logic [bitwidth-1:0] cnt_nxt;
  logic [1:0]          cause_nxt;
  logic                both_req;
  logic                one_req;

  assign both_req = highside_request & lowside_request;
  assign one_req  = highside_request ^ lowside_request;

  // Next-state decode. The if/else order is the priority order:
  // fault > overlap > enable low > normal transitions.
  always_comb begin
    nxt_state = cur_state;
    cnt_nxt   = cnt;
    cause_nxt = fault_cause;

    if (cur_state == FAULT) begin
      // Requests and enable are ignored here; only a clear with the fault
      // input already gone releases the latch.
      if (fault_clear && !fault) begin
        nxt_state = IDLE;
        cause_nxt = CAUSE_NONE;
      end
    end else if (cur_state == IDLE || cur_state == DEAD ||
                 cur_state == HS_ON || cur_state == LS_ON) begin
      if (fault) begin
        // Also covers fault and overlap in the same cycle.
        nxt_state = FAULT;
        cause_nxt = CAUSE_EXT;
      end else if (cur_state != IDLE && both_req) begin
        // Both requests in IDLE are harmless: the gates are already off.
        nxt_state = FAULT;
        cause_nxt = CAUSE_OVERLAP;
      end else if (!enable) begin
        nxt_state = IDLE;
      end else if (cur_state == IDLE) begin
        nxt_state = DEAD;
        cnt_nxt   = min_deadtime;
      end else if (cur_state == DEAD) begin
        // The counter parks at zero; a request that is still high when it
        // gets there is executed, one that dropped earlier is forgotten.
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (one_req) begin
          nxt_state = highside_request ? HS_ON : LS_ON;
        end
      end else if (cur_state == HS_ON) begin
        if (!highside_request) begin
          nxt_state = DEAD;
          cnt_nxt   = min_deadtime;
        end
      end else begin
        if (!lowside_request) begin
          nxt_state = DEAD;
          cnt_nxt   = min_deadtime;
        end
      end
    end else begin
      // Unused encodings fall back to the safe state.
      nxt_state = IDLE;
      cause_nxt = CAUSE_NONE;
      cnt_nxt   = '0;
    end
  end

  // Gates and fault flag are decoded from the next state so they are
  // registered and line up with the state register on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_state     <= IDLE;
      cnt           <= '0;
      fault_cause   <= CAUSE_NONE;
      highside_gate <= 1'b0;
      lowside_gate  <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      cur_state     <= nxt_state;
      cnt           <= cnt_nxt;
      fault_cause   <= cause_nxt;
      highside_gate <= (nxt_state == HS_ON);
      lowside_gate  <= (nxt_state == LS_ON);
      fault_latched <= (nxt_state == FAULT);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_gate_interlock.sv
module tb_gate_interlock;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       highside_request;
  logic       lowside_request;
  logic [7:0] min_deadtime;
  logic       fault;
  logic       fault_clear;
  logic       highside_gate;
  logic       lowside_gate;
  logic       fault_latched;
  logic [1:0] fault_cause;
  logic [2:0] state;

  gate_interlock #(.bitwidth(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .highside_request (highside_request),
    .lowside_request  (lowside_request),
    .min_deadtime     (min_deadtime),
    .fault            (fault),
    .fault_clear      (fault_clear),
    .highside_gate    (highside_gate),
    .lowside_gate     (lowside_gate),
    .fault_latched    (fault_latched),
    .fault_cause      (fault_cause),
    .state            (state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       en;
    logic       hs;
    logic       ls;
    logic [7:0] md;
    logic       f;
    logic       fc;
    logic [2:0] st;
    logic [1:0] cause;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic hs, input logic ls,
                              input logic [7:0] md, input logic f, input logic fc,
                              input logic [2:0] st, input logic [1:0] cause);
    vec_t v;
    v.en = en; v.hs = hs; v.ls = ls; v.md = md;
    v.f = f; v.fc = fc; v.st = st; v.cause = cause;
    vecs.push_back(v);
  endfunction

  // ---------------- scoreboard ----------------
  // {highside_gate, lowside_gate, fault_latched, fault_cause, state}
  logic [7:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_hs"},    highside_gate, 0);
    check({name, "_ls"},    lowside_gate, 0);
    check({name, "_fl"},    fault_latched, 0);
    check({name, "_cause"}, fault_cause, 0);
    check({name, "_state"}, state, 0);
  endtask

  // Driver: called away from the edge, drives one vector, records what the
  // outputs must be after the next rising edge, then compares.
  task automatic apply(input vec_t v, input int idx);
    logic [7:0] e;
    enable           = v.en;
    highside_request = v.hs;
    lowside_request  = v.ls;
    min_deadtime     = v.md;
    fault            = v.f;
    fault_clear      = v.fc;
    exp_q.push_back({(v.st == 3'd2), (v.st == 3'd3), (v.st == 3'd4), v.cause, v.st});
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check($sformatf("v%0d_queue_empty", idx), 0, 1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("v%0d_state", idx), state, e[2:0]);
      check($sformatf("v%0d_cause", idx), fault_cause, e[4:3]);
      check($sformatf("v%0d_fault_latched", idx), fault_latched, e[5]);
      check($sformatf("v%0d_ls_gate", idx), lowside_gate, e[6]);
      check($sformatf("v%0d_hs_gate", idx), highside_gate, e[7]);
    end
    fault_clear = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;

    // Stimulus table: en hs ls md f fc -> state cause (after the edge)
    // 1: startup, md=3 -> 4 clocks of DEAD, highside on the 5th edge
    for (int i = 0; i < 4; i++) add(1, 1, 0, 3, 0, 0, 1, 0);
    add(1, 1, 0, 3, 0, 0, 2, 0);
    add(1, 1, 0, 3, 0, 0, 2, 0);
    // 2: hs->ls handover with md=5, md changed mid-count has no effect
    add(1, 0, 1, 5, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 1, 9, 0, 0, 1, 0);
    add(1, 0, 1, 5, 0, 0, 1, 0);
    add(1, 0, 1, 5, 0, 0, 3, 0);
    // upstream gap shorter than deadtime is stretched; deferred request runs
    add(1, 0, 0, 2, 0, 0, 1, 0);
    add(1, 0, 0, 2, 0, 0, 1, 0);
    add(1, 1, 0, 2, 0, 0, 1, 0);
    add(1, 1, 0, 2, 0, 0, 2, 0);
    // request that drops before the count expires is never executed
    add(1, 0, 0, 2, 0, 0, 1, 0);
    add(1, 1, 0, 2, 0, 0, 1, 0);
    add(1, 0, 0, 2, 0, 0, 1, 0);
    add(1, 0, 0, 2, 0, 0, 1, 0);
    add(1, 0, 1, 2, 0, 0, 3, 0);
    // md=0 gives a single-clock gap
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 0, 3, 0);
    // both requests in IDLE are not a fault
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 2, 0);
    // 3: overlap pulse in HS_ON latches cause 2, requests then ignored
    add(1, 1, 1, 0, 0, 0, 4, 2);
    for (int i = 0; i < 20; i++) add(1, i[0], i[1], 0, 0, 0, 4, 2);
    add(1, 0, 0, 0, 0, 1, 0, 0);
    // 4: external fault in LS_ON, clear while fault high is ignored
    add(1, 0, 1, 1, 0, 0, 1, 0);
    add(1, 0, 1, 1, 0, 0, 1, 0);
    add(1, 0, 1, 1, 0, 0, 3, 0);
    add(1, 0, 1, 1, 1, 0, 4, 1);
    add(1, 0, 1, 1, 1, 0, 4, 1);
    add(1, 0, 1, 1, 1, 1, 4, 1);
    add(1, 0, 1, 1, 0, 0, 4, 1);
    add(1, 0, 1, 1, 0, 1, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, 0);
    add(1, 0, 1, 1, 0, 0, 1, 0);
    add(1, 0, 1, 1, 0, 0, 3, 0);
    // fault and overlap together report the external fault
    add(1, 1, 1, 1, 1, 0, 4, 1);
    add(0, 0, 0, 1, 0, 1, 0, 0);
    // fault taken from IDLE too
    add(0, 0, 0, 1, 1, 0, 4, 1);
    add(0, 0, 0, 1, 0, 1, 0, 0);
    // 5: enable drop in HS_ON, then md+1 clocks of DEAD on restore
    add(1, 1, 0, 2, 0, 0, 1, 0);
    add(1, 1, 0, 2, 0, 0, 1, 0);
    add(1, 1, 0, 2, 0, 0, 1, 0);
    add(1, 1, 0, 2, 0, 0, 2, 0);
    add(0, 1, 0, 2, 0, 0, 0, 0);
    add(1, 1, 0, 2, 0, 0, 1, 0);
    add(1, 1, 0, 2, 0, 0, 1, 0);
    add(1, 1, 0, 2, 0, 0, 1, 0);
    add(1, 1, 0, 2, 0, 0, 2, 0);
    // overlap outranks enable low
    add(0, 1, 1, 2, 0, 0, 4, 2);
    add(0, 0, 0, 2, 0, 1, 0, 0);
    // set up LS_ON for the async reset sequence
    add(1, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 0, 3, 0);

    // reset state
    reset            = 1'b0;
    enable           = 1'b0;
    highside_request = 1'b0;
    lowside_request  = 1'b0;
    min_deadtime     = 8'd0;
    fault            = 1'b0;
    fault_clear      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i);

    // 6: async reset mid-clock during LS_ON
    check("pre_reset_ls_gate", lowside_gate, 1);
    #3;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clock);
    #1;
    check_all_zero("held_reset");
    reset = 1'b1;
    v.en = 1; v.hs = 0; v.ls = 1; v.md = 0; v.f = 0; v.fc = 0; v.st = 1; v.cause = 0;
    apply(v, 1000);
    v.st = 3;
    apply(v, 1001);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
